// File: rtl/mag_bus_pkg.sv
// Shared host-bus constants, FSM state encoding and byte-lane merge helper.
// Used by the register bank top and its per-channel registers.
package mag_bus_pkg;

  localparam logic [11:0] CTRL_OFS   = 12'h3F0;
  localparam logic [11:0] STATUS_OFS = 12'h3F4;
  localparam logic [11:0] IRQ_EN_OFS = 12'h3F8;
  localparam logic [11:0] ID_OFS     = 12'h3FC;

  localparam logic [31:0] DEF_ID_VALUE = 32'h4D41_4701;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_WR_ERR  = 2;
  localparam int ST_NCH_LSB = 8;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } fsm_state_e;

  // Replace each byte of old_w whose write-enable bit is set with the byte from new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mag_ch_reg.sv
// One 64-bit channel: low-word writes land in a shadow; a high-word write commits {high, shadow}
// one cycle later with a single-cycle update pulse. No backpressure; writes are accepted every cycle.
module mag_ch_reg
  import mag_bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_we_lo,
  input  logic [3:0]  i_we_hi,
  input  logic        i_clr,
  input  logic [31:0] i_wdat,
  output logic [63:0] o_value,
  output logic        o_update
);

  logic [31:0] r_shadow;
  logic [63:0] r_value;
  logic        r_update;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_value  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (i_clr) begin
        r_shadow <= '0;
        r_value  <= '0;
      end else begin
        if (|i_we_lo) begin
          r_shadow <= lane_merge(r_shadow, i_wdat, i_we_lo);
        end
        // Unwritten high-word lanes keep their committed bytes.
        if (|i_we_hi) begin
          r_value  <= {lane_merge(r_value[63:32], i_wdat, i_we_hi), r_shadow};
          r_update <= 1'b1;
        end
      end
    end
  end

  assign o_value  = r_value;
  assign o_update = r_update;

endmodule

// File: rtl/mag_host_regbank.sv
// Host-bus register bank: channel decode, registered read mux (latency 1), start/done FSM, sticky flags.
// The bus has no wait states: writes take effect at the strobed edge, reads return on the next cycle.
module mag_host_regbank
  import mag_bus_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] ID_VALUE = DEF_ID_VALUE
) (
  input  logic                  BCLK,
  input  logic                  Reset,
  input  logic [ADDR_W-1:0]     Address,
  input  logic                  nCS,
  input  logic                  nRD,
  input  logic [3:0]            nWR,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  DataOE,
  output logic [NUM_CH*64-1:0]  ChValue,
  output logic [NUM_CH-1:0]     ChUpdate,
  output logic                  Start,
  input  logic                  CoreDone,
  output logic                  Irq
);

  localparam int CH_W = ADDR_W - 3;

  fsm_state_e        r_state;
  fsm_state_e        w_state_nxt;
  logic [31:0]       r_dout;
  logic              r_oe;
  logic              r_done;
  logic              r_wr_err;
  logic              r_irq_en;

  logic [3:0]        w_lane_we;
  logic              w_any_we;
  logic              w_rd;
  logic [ADDR_W-1:0] w_waddr;
  logic [CH_W-1:0]   w_ch_idx;
  logic              w_ch_hit;
  logic              w_is_ctrl;
  logic              w_is_status;
  logic              w_is_irq_en;
  logic              w_is_id;
  logic              w_idle;
  logic              w_ch_wr;
  logic              w_err_set;
  logic              w_start;
  logic              w_clr;
  logic              w_stat_rd;
  logic [31:0]       w_status;
  logic [31:0]       w_rdat;
  logic              w_unused;

  assign w_lane_we   = {4{~nCS}} & ~nWR;
  assign w_any_we    = |w_lane_we;
  assign w_rd        = ~nCS & ~nRD;
  assign w_waddr     = {Address[ADDR_W-1:2], 2'b00};
  assign w_ch_idx    = Address[ADDR_W-1:3];
  assign w_ch_hit    = (w_ch_idx < CH_W'(NUM_CH));
  assign w_is_ctrl   = (w_waddr == ADDR_W'(CTRL_OFS));
  assign w_is_status = (w_waddr == ADDR_W'(STATUS_OFS));
  assign w_is_irq_en = (w_waddr == ADDR_W'(IRQ_EN_OFS));
  assign w_is_id     = (w_waddr == ADDR_W'(ID_OFS));
  assign w_unused    = ^Address[1:0];

  // Channel contents are frozen while the core owns them; a write attempt is flagged instead.
  assign w_idle      = (r_state == S_IDLE);
  assign w_ch_wr     = w_any_we & w_ch_hit & w_idle;
  assign w_err_set   = w_any_we & w_ch_hit & ~w_idle;
  assign w_start     = w_is_ctrl & w_lane_we[0] & DataIn[CTRL_START] & w_idle;
  assign w_clr       = w_is_ctrl & w_lane_we[0] & DataIn[CTRL_CLEAR] & w_idle;
  assign w_stat_rd   = w_rd & w_is_status;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic       w_sel;
    logic [3:0] w_we_lo;
    logic [3:0] w_we_hi;

    assign w_sel   = w_ch_wr & (w_ch_idx == CH_W'(g));
    assign w_we_lo = (w_sel & ~Address[2]) ? w_lane_we : 4'b0000;
    assign w_we_hi = (w_sel &  Address[2]) ? w_lane_we : 4'b0000;

    mag_ch_reg u_ch (
      .i_clk    (BCLK),
      .i_rst    (Reset),
      .i_we_lo  (w_we_lo),
      .i_we_hi  (w_we_hi),
      .i_clr    (w_clr),
      .i_wdat   (DataIn),
      .o_value  (ChValue[64*g +: 64]),
      .o_update (ChUpdate[g])
    );
  end

  always_comb begin
    w_status                      = '0;
    w_status[ST_BUSY]             = ~w_idle;
    w_status[ST_DONE]             = r_done;
    w_status[ST_WR_ERR]           = r_wr_err;
    w_status[ST_NCH_LSB +: 8]     = 8'(NUM_CH);
  end

  // Reads see the state before any write in the same cycle; shadows are never readable.
  always_comb begin
    w_rdat = '0;
    if (w_ch_hit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_ch_idx == CH_W'(k)) begin
          w_rdat = Address[2] ? ChValue[64*k + 32 +: 32] : ChValue[64*k +: 32];
        end
      end
    end else if (w_is_status) begin
      w_rdat = w_status;
    end else if (w_is_irq_en) begin
      w_rdat = {31'b0, r_irq_en};
    end else if (w_is_id) begin
      w_rdat = ID_VALUE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Start       = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        Start       = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:    if (CoreDone) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge BCLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flag being set in the same cycle as a clearing STATUS read stays set.
  always_ff @(posedge BCLK) begin
    if (Reset) begin
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_oe     <= w_rd;
      r_dout   <= w_rd ? w_rdat : 32'h0;
      r_done   <= (r_state == S_DONE) | (r_done & ~w_stat_rd);
      r_wr_err <= w_err_set | (r_wr_err & ~w_stat_rd);
      if (w_is_irq_en & w_lane_we[0]) begin
        r_irq_en <= DataIn[0];
      end
    end
  end

  assign DataOut = r_dout;
  assign DataOE  = r_oe;
  assign Irq     = r_done & r_irq_en;

endmodule

// File: tb/tb_mag_host_regbank.sv
// Directed + randomized bench for mag_host_regbank against a word-level model of the register map.
module tb_mag_host_regbank;

  localparam int NCH = 4;

  logic             BCLK = 1'b0;
  logic             Reset;
  logic [9:0]       Address;
  logic             nCS;
  logic             nRD;
  logic [3:0]       nWR;
  logic [31:0]      DataIn;
  logic [31:0]      DataOut;
  logic             DataOE;
  logic [NCH*64-1:0] ChValue;
  logic [NCH-1:0]   ChUpdate;
  logic             Start;
  logic             CoreDone;
  logic             Irq;

  mag_host_regbank #(.NUM_CH(NCH), .ADDR_W(10), .ID_VALUE(32'h4D41_4701)) dut (
    .BCLK     (BCLK),
    .Reset    (Reset),
    .Address  (Address),
    .nCS      (nCS),
    .nRD      (nRD),
    .nWR      (nWR),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .DataOE   (DataOE),
    .ChValue  (ChValue),
    .ChUpdate (ChUpdate),
    .Start    (Start),
    .CoreDone (CoreDone),
    .Irq      (Irq)
  );

  always #5 BCLK = ~BCLK;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  // Word-level model of what the host should observe.
  logic [31:0] m_sh [NCH];
  logic [31:0] m_lo [NCH];
  logic [31:0] m_hi [NCH];
  bit          m_busy;
  bit          m_done;
  bit          m_err;
  bit          m_ien;
  int          m_starts = 0;
  logic [31:0] rd_val;

  always @(posedge BCLK) if (Start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] nwr);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (!nwr[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [255:0] m_chv();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[64*k +: 64] = {m_hi[k], m_lo[k]};
    return v;
  endfunction

  function automatic logic [31:0] m_status();
    return (32'(NCH) << 8) | (32'(m_err) << 2) | (32'(m_done) << 1) | 32'(m_busy);
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    logic [9:0] wa;
    int k;
    wa = a & 10'h3FC;
    k  = int'(wa[9:3]);
    if (k < NCH) return wa[2] ? m_hi[k] : m_lo[k];
    case (wa)
      10'h3F4: return m_status();
      10'h3F8: return {31'b0, m_ien};
      10'h3FC: return 32'h4D41_4701;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_sh[k] = '0; m_lo[k] = '0; m_hi[k] = '0;
    end
    m_busy = 0; m_done = 0; m_err = 0; m_ien = 0;
  endtask

  task automatic do_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] nwr);
    logic [9:0] wa;
    logic [3:0] exp_upd;
    bit exp_start;
    int k;
    wa = a & 10'h3FC;
    k = int'(wa[9:3]);
    exp_upd = '0;
    exp_start = 0;
    if (nwr != 4'hF) begin
      if (k < NCH) begin
        if (m_busy) m_err = 1;
        else if (!wa[2]) m_sh[k] = merge(m_sh[k], d, nwr);
        else begin
          m_hi[k] = merge(m_hi[k], d, nwr);
          m_lo[k] = m_sh[k];
          exp_upd[k] = 1'b1;
        end
      end else if (wa == 10'h3F0 && !nwr[0] && !m_busy) begin
        if (d[1]) for (int j = 0; j < NCH; j++) begin
          m_sh[j] = '0; m_lo[j] = '0; m_hi[j] = '0;
        end
        if (d[0]) begin
          m_busy = 1; exp_start = 1; m_starts++;
        end
      end else if (wa == 10'h3F8 && !nwr[0]) begin
        m_ien = d[0];
      end
    end
    @(negedge BCLK);
    Address = a; DataIn = d; nWR = nwr; nCS = 1'b0;
    @(negedge BCLK);
    chk("wr_update", ChUpdate, exp_upd);
    chk("wr_chvalue", ChValue, m_chv());
    chk("wr_start", Start, exp_start);
    chk("wr_irq", Irq, m_done & m_ien);
    nCS = 1'b1; nWR = 4'hF;
  endtask

  task automatic do_rd(input logic [9:0] a);
    logic [31:0] exp;
    exp = m_read(a);
    if ((a & 10'h3FC) == 10'h3F4) begin
      m_done = 0; m_err = 0;
    end
    @(negedge BCLK);
    Address = a; nCS = 1'b0; nRD = 1'b0;
    @(negedge BCLK);
    rd_val = DataOut;
    chk("rd_data", DataOut, exp);
    chk("rd_oe", DataOE, 1'b1);
    chk("rd_irq", Irq, m_done & m_ien);
    nCS = 1'b1; nRD = 1'b1;
    @(negedge BCLK);
    chk("rd_oe_drop", DataOE, 1'b0);
  endtask

  task automatic core_done();
    @(negedge BCLK); CoreDone = 1'b1;
    @(negedge BCLK); CoreDone = 1'b0;
    @(negedge BCLK);
    if (m_busy) begin
      m_busy = 0; m_done = 1;
    end
    chk("done_irq", Irq, m_done & m_ien);
  endtask

  initial begin
    logic [9:0] ra;
    logic [3:0] rn;
    int op;
    Reset = 1'b1; nCS = 1'b1; nRD = 1'b1; nWR = 4'hF;
    Address = '0; DataIn = '0; CoreDone = 1'b0;
    m_reset();
    repeat (10) @(negedge BCLK);
    chk("rst_dout", DataOut, 32'h0);
    chk("rst_oe", DataOE, 1'b0);
    chk("rst_chv", ChValue, '0);
    chk("rst_upd", ChUpdate, '0);
    chk("rst_start", Start, 1'b0);
    chk("rst_irq", Irq, 1'b0);
    Reset = 1'b0;

    // Channel 0 commit
    do_wr(10'h000, 32'h0000_0000, 4'h0);
    do_wr(10'h004, 32'h3FF0_0000, 4'h0);
    chk("t1_ch0", ChValue[63:0], 64'h3FF0_0000_0000_0000);
    do_wr(10'h000, 32'hDEAD_BEEF, 4'h0);
    chk("t1_lo_only", ChValue[63:0], 64'h3FF0_0000_0000_0000);

    // Partial low write stays hidden until commit
    do_wr(10'h008, 32'h1234_5678, 4'b1100);
    do_rd(10'h008);
    chk("t2_pre", rd_val, 32'h0);
    do_wr(10'h00C, 32'h4000_0000, 4'h0);
    do_rd(10'h008);
    chk("t2_post", rd_val, 32'h0000_5678);
    chk("t2_ch1", ChValue[127:64], 64'h4000_0000_0000_5678);

    // Start/done handshake and interrupt
    do_wr(10'h3F8, 32'h1, 4'h0);
    do_wr(10'h3F0, 32'h1, 4'h0);
    do_rd(10'h3F4);
    chk("t3_busy", rd_val, 32'h0000_0401);
    core_done();
    chk("t3_irq", Irq, 1'b1);
    do_rd(10'h3F4);
    chk("t3_st1", rd_val, 32'h0000_0402);
    do_rd(10'h3F4);
    chk("t3_st2", rd_val, 32'h0000_0400);
    chk("t3_irq_clr", Irq, 1'b0);

    // Writes during RUN are dropped and flagged
    do_wr(10'h3F0, 32'h1, 4'h0);
    do_wr(10'h004, 32'h1111_1111, 4'h0);
    do_wr(10'h3F0, 32'h1, 4'h0);
    repeat (3) @(negedge BCLK);
    chk("t4_starts", start_cnt, m_starts);
    do_rd(10'h3F4);
    chk("t4_err", rd_val, 32'h0000_0405);
    core_done();
    do_rd(10'h3F4);
    chk("t4_done", rd_val, 32'h0000_0402);

    // ID, out-of-range channel, stray CoreDone, clear
    do_rd(10'h3FC);
    chk("t5_id", rd_val, 32'h4D41_4701);
    do_rd(10'h100);
    do_wr(10'h100, 32'hFFFF_FFFF, 4'h0);
    do_wr(10'h104, 32'hFFFF_FFFF, 4'h0);
    core_done();
    do_rd(10'h3F0);
    do_wr(10'h3F0, 32'h2, 4'h0);
    chk("t5_clear", ChValue, '0);

    // Randomized channel traffic while idle
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 3);
      ra = 10'($urandom_range(0, 5) * 8 + $urandom_range(0, 1) * 4 + $urandom_range(0, 3));
      rn = 4'($urandom_range(0, 15));
      if (op == 3) do_rd(ra);
      else do_wr(ra, $urandom, rn);
    end
    do_rd(10'h3F8);
    do_rd(10'h3F4);

    // Reset during RUN
    do_wr(10'h000, 32'hAAAA_5555, 4'h0);
    do_wr(10'h004, 32'h4010_0000, 4'h0);
    do_wr(10'h3F0, 32'h1, 4'h0);
    @(negedge BCLK);
    Address = 10'h3FC; nCS = 1'b0; nRD = 1'b0;
    @(negedge BCLK);
    chk("t6_oe_pre", DataOE, 1'b1);
    nCS = 1'b1; nRD = 1'b1; Reset = 1'b1;
    @(negedge BCLK);
    m_reset();
    chk("t6_chv", ChValue, '0);
    chk("t6_irq", Irq, 1'b0);
    chk("t6_oe", DataOE, 1'b0);
    chk("t6_start", Start, 1'b0);
    Reset = 1'b0;
    do_rd(10'h3F4);
    chk("t6_status", rd_val, 32'h0000_0400);
    chk("t6_starts", start_cnt, m_starts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
